// File: rtl/traffic_light_monitor_if.sv
// Signal bundle between the intersection controller side (master) and the
// light-sequence monitor (slave): light codes and sensor in, status out.
interface traffic_light_monitor_if #(
  parameter int DW_W  = 8,
  parameter int CNT_W = 16
);
  logic [1:0]       ns;
  logic [1:0]       ew;
  logic             x;
  logic [2:0]       phase;
  logic [DW_W-1:0]  dwell;
  logic             fault;
  logic [2:0]       fault_code;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output ns, ew, x,
    input  phase, dwell, fault, fault_code, cycle_count
  );

  modport slave (
    input  ns, ew, x,
    output phase, dwell, fault, fault_code, cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the NS/EW light-code sequence with sticky fault.
// Optional NS-stuck watchdog enabled by defining TLMON_STUCK_EN.
module traffic_light_monitor #(
  parameter int YEL_MIN = 3,
  parameter int YEL_MAX = 4,
  parameter int EWG_MIN = 8,
  parameter int NSG_MAX = 20,
  parameter int DW_W    = 8,
  parameter int CNT_W   = 16
) (
  input logic                    clk,
  input logic                    clear,
  traffic_light_monitor_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NS    = 3'd1,
    S_Y1    = 3'd2,
    S_EW    = 3'd3,
    S_Y2    = 3'd4,
    S_FAULT = 3'd7
  } state_e;

  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YEL = 2'd1;
  localparam logic [1:0] GRN = 2'd2;
  localparam logic [1:0] ILL = 2'd3;

  localparam logic [3:0] P_NS = {GRN, RED};
  localparam logic [3:0] P_YY = {YEL, YEL};
  localparam logic [3:0] P_EW = {RED, GRN};

  state_e           state_q, state_d, nom_state, adv_state;
  logic [DW_W-1:0]  dwell_q, dwell_d, nom_dwell, dwell_inc;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d, code_sel;
  logic [CNT_W-1:0] cc_q, cc_d, nom_cc;

  logic [3:0] pair, exp_cur, exp_nxt;
  logic       check_en, is_yel;
  logic       illegal, conflict, viol_seq, yel_short, yel_long, ew_short, stuck;

  assign pair      = {bus.ns, bus.ew};
  assign check_en  = (state_q != S_FAULT);
  assign is_yel    = (state_q == S_Y1) || (state_q == S_Y2);
  assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;

  assign illegal  = check_en && ((bus.ns == ILL) || (bus.ew == ILL));
  assign conflict = check_en &&
                    (((bus.ns == GRN) && ((bus.ew == GRN) || (bus.ew == YEL))) ||
                     ((bus.ew == GRN) && (bus.ns == YEL)));

  always_comb begin
    exp_cur   = '0;
    exp_nxt   = '0;
    adv_state = state_q;
    case (state_q)
      S_NS:    begin exp_cur = P_NS; exp_nxt = P_YY; adv_state = S_Y1; end
      S_Y1:    begin exp_cur = P_YY; exp_nxt = P_EW; adv_state = S_EW; end
      S_EW:    begin exp_cur = P_EW; exp_nxt = P_YY; adv_state = S_Y2; end
      S_Y2:    begin exp_cur = P_YY; exp_nxt = P_NS; adv_state = S_NS; end
      default: begin exp_cur = '0;   exp_nxt = '0;   adv_state = state_q; end
    endcase
  end

  // Nominal (fault-free) next values; violations override them below.
  always_comb begin
    nom_state = state_q;
    nom_dwell = dwell_q;
    nom_cc    = cc_q;
    viol_seq  = 1'b0;
    yel_short = 1'b0;
    yel_long  = 1'b0;
    ew_short  = 1'b0;
    if (state_q == S_IDLE) begin
      if (pair == P_NS) begin
        nom_state = S_NS;
        nom_dwell = DW_W'(1);
      end else begin
        nom_dwell = '0;
      end
    end else if (check_en) begin
      if (pair == exp_cur) begin
        nom_dwell = dwell_inc;
        yel_long  = is_yel && (dwell_q >= DW_W'(YEL_MAX));
      end else if (pair == exp_nxt) begin
        nom_state = adv_state;
        nom_dwell = DW_W'(1);
        yel_short = is_yel && (dwell_q < DW_W'(YEL_MIN));
        ew_short  = (state_q == S_EW) && (dwell_q < DW_W'(EWG_MIN));
        if (state_q == S_Y2) begin
          nom_cc = (cc_q == '1) ? cc_q : cc_q + 1'b1;
        end
      end else begin
        viol_seq = 1'b1;
      end
    end
  end

`ifdef TLMON_STUCK_EN
  localparam int SW = $clog2(NSG_MAX + 2);
  logic [SW-1:0] stk_q, stk_d;

  always_comb begin
    stk_d = '0;
    stuck = 1'b0;
    if (check_en && (nom_state == S_NS) && bus.x) begin
      stuck = (stk_q == SW'(NSG_MAX));
      stk_d = stk_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) stk_q <= '0;
    else       stk_q <= stk_d;
  end
`else
  logic unused_x;
  assign unused_x = bus.x ^ NSG_MAX[0];
  assign stuck    = 1'b0;
`endif

  // Later assignments take precedence, so the lowest code wins.
  always_comb begin
    code_sel = 3'd0;
    if (stuck)     code_sel = 3'd7;
    if (ew_short)  code_sel = 3'd6;
    if (yel_long)  code_sel = 3'd5;
    if (yel_short) code_sel = 3'd4;
    if (viol_seq)  code_sel = 3'd3;
    if (conflict)  code_sel = 3'd2;
    if (illegal)   code_sel = 3'd1;
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    fault_d = fault_q;
    code_d  = code_q;
    cc_d    = cc_q;
    if (code_sel != 3'd0) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
      code_d  = code_sel;
    end else if (check_en) begin
      state_d = nom_state;
      dwell_d = nom_dwell;
      cc_d    = nom_cc;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      dwell_q <= '0;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      cc_q    <= cc_d;
    end
  end

  assign bus.phase       = state_q;
  assign bus.dwell       = dwell_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = code_q;
  assign bus.cycle_count = cc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed light-code vectors with
// hand-computed expected status, checked by an independent monitor process.
module tb_traffic_light_monitor;
  localparam int DW_W  = 8;
  localparam int CNT_W = 16;
  localparam int DSAT  = (1 << DW_W) - 1;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] Y = 2'd1;
  localparam logic [1:0] G = 2'd2;
  localparam logic [1:0] I = 2'd3;

  localparam logic [2:0] PI = 3'd0;
  localparam logic [2:0] PN = 3'd1;
  localparam logic [2:0] P1 = 3'd2;
  localparam logic [2:0] PE = 3'd3;
  localparam logic [2:0] P2 = 3'd4;
  localparam logic [2:0] PF = 3'd7;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  traffic_light_monitor_if #(.DW_W(DW_W), .CNT_W(CNT_W)) bus ();

  traffic_light_monitor #(
    .YEL_MIN(3), .YEL_MAX(4), .EWG_MIN(8), .NSG_MAX(20),
    .DW_W(DW_W), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus)
  );

  typedef struct {
    int               cyc;
    logic [2:0]       ph;
    logic [DW_W-1:0]  dw;
    logic             f;
    logic [2:0]       code;
    logic [CNT_W-1:0] cc;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s.%s: got %0d, expected %0d", tag, name, act, req);
    end
  endtask

  // Pops only entries whose sampling edge has already happened.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("phase",       e.tag, 32'(bus.phase),       32'(e.ph));
        chk("dwell",       e.tag, 32'(bus.dwell),       32'(e.dw));
        chk("fault",       e.tag, 32'(bus.fault),       32'(e.f));
        chk("fault_code",  e.tag, 32'(bus.fault_code),  32'(e.code));
        chk("cycle_count", e.tag, 32'(bus.cycle_count), 32'(e.cc));
      end
    end
  end

  task automatic drive(input logic c, input logic [1:0] n, input logic [1:0] e_, input logic xx,
                       input logic [2:0] ph, input int dw, input logic f, input logic [2:0] code,
                       input int cc, input string tag);
    exp_t t;
    @(negedge clk);
    clear  = c;
    bus.ns = n;
    bus.ew = e_;
    bus.x  = xx;
    t.cyc  = cyc;
    t.ph   = ph;
    t.dw   = DW_W'(dw);
    t.f    = f;
    t.code = code;
    t.cc   = CNT_W'(cc);
    t.tag  = tag;
    sb.push_back(t);
  endtask

  // cnt samples of one pair; expected dwell counts up from d0 and saturates.
  task automatic run(input logic [1:0] n, input logic [1:0] e_, input logic xx, input int cnt,
                     input logic [2:0] ph, input int d0, input int cc, input string tag);
    int d;
    for (int i = 0; i < cnt; i++) begin
      d = (d0 + i > DSAT) ? DSAT : d0 + i;
      drive(1'b0, n, e_, xx, ph, d, 1'b0, 3'd0, cc, tag);
    end
  endtask

  task automatic rst();
    drive(1'b1, R, R, 1'b0, PI, 0, 1'b0, 3'd0, 0, "clear");
  endtask

  initial begin
    int waitc;
    clear  = 1'b1;
    bus.ns = R;
    bus.ew = R;
    bus.x  = 1'b0;

    rst(); rst();
    drive(0, R, R, 0, PI, 0, 0, 0, 0, "idle_rr");
    drive(0, Y, Y, 0, PI, 0, 0, 0, 0, "idle_yy");
    drive(0, R, G, 0, PI, 0, 0, 0, 0, "idle_rg");

    // Legal loop, then a second lap, then conflict from NS_GO and clear.
    run(G, R, 0, 5, PN, 1, 0, "loop_ns");
    run(Y, Y, 0, 3, P1, 1, 0, "loop_y1");
    run(R, G, 0, 8, PE, 1, 0, "loop_ew");
    run(Y, Y, 0, 4, P2, 1, 0, "loop_y2");
    run(G, R, 0, 1, PN, 1, 1, "loop_ns2");
    run(Y, Y, 0, 3, P1, 1, 1, "lap2_y1");
    run(R, G, 0, 8, PE, 1, 1, "lap2_ew");
    run(Y, Y, 0, 3, P2, 1, 1, "lap2_y2");
    run(G, R, 0, 2, PN, 1, 2, "lap2_ns");
    drive(0, G, G, 0, PF, 2, 1, 2, 2, "conflict_gg");
    drive(0, G, R, 0, PF, 2, 1, 2, 2, "fault_hold");
    rst();

    run(G, R, 0, 5, PN, 1, 0, "sy_ns");
    run(Y, Y, 0, 2, P1, 1, 0, "sy_y1");
    drive(0, R, G, 0, PF, 2, 1, 4, 0, "short_y1");
    rst();

    run(G, R, 0, 2, PN, 1, 0, "ly_ns");
    run(Y, Y, 0, 4, P1, 1, 0, "ly_y1");
    drive(0, Y, Y, 0, PF, 4, 1, 5, 0, "long_y1");
    drive(0, Y, Y, 0, PF, 4, 1, 5, 0, "long_hold");
    rst();

    run(G, R, 0, 1, PN, 1, 0, "es_ns");
    run(Y, Y, 0, 3, P1, 1, 0, "es_y1");
    run(R, G, 0, 7, PE, 1, 0, "es_ew");
    drive(0, Y, Y, 0, PF, 7, 1, 6, 0, "short_ew");
    rst();

    run(G, R, 0, 1, PN, 1, 0, "s2_ns");
    run(Y, Y, 0, 3, P1, 1, 0, "s2_y1");
    run(R, G, 0, 8, PE, 1, 0, "s2_ew");
    run(Y, Y, 0, 2, P2, 1, 0, "s2_y2");
    drive(0, G, R, 0, PF, 2, 1, 4, 0, "short_y2");
    rst();

    drive(0, I, R, 0, PF, 0, 1, 1, 0, "illegal_idle");
    rst();
    run(G, R, 0, 1, PN, 1, 0, "il_ns");
    drive(0, G, I, 0, PF, 1, 1, 1, 0, "illegal_ns");
    rst();
    run(G, R, 0, 2, PN, 1, 0, "oos_ns");
    drive(0, R, G, 0, PF, 2, 1, 3, 0, "oos_skip_y");
    rst();
    run(G, R, 0, 1, PN, 1, 0, "oos2_ns");
    run(Y, Y, 0, 3, P1, 1, 0, "oos2_y1");
    drive(0, G, R, 0, PF, 3, 1, 3, 0, "oos_back_ns");
    rst();
    drive(0, Y, G, 0, PF, 0, 1, 2, 0, "conflict_idle");
    rst();

    run(G, R, 0, 260, PN, 1, 0, "dwell_sat");
    rst();

`ifdef TLMON_STUCK_EN
    run(G, R, 1, 20, PN, 1, 0, "stk_run");
    drive(0, G, R, 1, PF, 20, 1, 7, 0, "stuck");
    rst();
    run(G, R, 1, 14, PN, 1, 0, "stk_a");
    drive(0, G, R, 0, PN, 15, 0, 0, 0, "stk_drop");
    run(G, R, 1, 20, PN, 16, 0, "stk_b");
    rst();
`else
    run(G, R, 1, 30, PN, 1, 0, "no_stuck");
    rst();
`endif

    waitc = 0;
    while (sb.size() > 0 && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
